fifo_stream_reader: RTL

//  Read-side controller for the 4-entry byte FIFO. Pops bytes through rd_en/empty/data_out,

---
 rtl/fifo_pkg.sv | 18 +
 rtl/stream_buf2.sv | 74 +++++++
 rtl/stream_buf2_chk.sv | 11 +
 rtl/fifo_stream_reader.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-FIFO read side: default width, reader states,
// and the in-flight byte count used to throttle FIFO pops.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Bytes that will be held after this cycle: buffered + arriving - leaving.
  function automatic logic [2:0] inflight(input logic [1:0] occ, input logic pend, input logic pop);
    return {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order byte buffer; the head entry is the registered stream output.
module stream_buf2 import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] tail_r;
  logic [1:0]        occ_r;
  logic              rd_s;

  // Reads of an empty buffer are ignored.
  always_comb begin
    rd_s = 1'b0;
    if (occ_r != 2'd0) begin
      rd_s = rd;
    end else begin
      rd_s = 1'b0;
    end
  end

  // Entry storage and occupancy; the head always holds the oldest byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_r <= {DATA_W{1'b0}};
      tail_r <= {DATA_W{1'b0}};
      occ_r  <= 2'd0;
    end else begin
      case ({wr, rd_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_r <= wdata;
          end else begin
            tail_r <= wdata;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          head_r <= tail_r;
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_r <= wdata;
          end else begin
            head_r <= tail_r;
            tail_r <= wdata;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign rdata = head_r;
  assign occ   = occ_r;

  stream_buf2_chk u_chk (
    .clk  (clk),
    .rstn (rstn),
    .wr   (wr),
    .occ  (occ_r)
  );

endmodule

// File: rtl/stream_buf2_chk.sv
// Simulation checker for stream_buf2: a write must never land in a full buffer.
module stream_buf2_chk (
  input logic       clk,
  input logic       rstn,
  input logic       wr,
  input logic [1:0] occ
);

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rstn) !(wr && (occ == 2'd2)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: pops bytes (1-cycle read latency) into a 2-entry buffer
// and streams them out on valid/ready, framed into FRAME_LEN-byte packets.
module fifo_stream_reader import fifo_pkg::*; #(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int FRAME_LEN = 4,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  rd_state_e         state_r;
  rd_state_e         state_nxt_s;
  logic              pend_r;
  logic [BEAT_W-1:0] beat_r;
  logic [FCNT_W-1:0] frame_cnt_r;
  logic [1:0]        occ_s;
  logic              pop_s;
  logic              held_s;

  assign out_valid = (occ_s != 2'd0);
  assign pop_s     = out_valid & out_ready;
  assign out_last  = out_valid & (beat_r == LAST_BEAT);
  assign held_s    = pend_r | (occ_s != 2'd0);
  assign frame_cnt = frame_cnt_r;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: DRAIN keeps delivering held bytes after enable falls.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (enable) begin
          state_nxt_s = RUN;
        end else if (held_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_nxt_s = RUN;
        end else if (!held_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs: pop only while the buffer can absorb every byte already in flight.
  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = (state_r != IDLE);
    if ((state_r == RUN) && enable && !fifo_empty && (inflight(occ_s, pend_r, pop_s) < 3'd2)) begin
      fifo_rd_en = 1'b1;
    end else begin
      fifo_rd_en = 1'b0;
    end
  end

  // Pending-read flag plus beat and completed-frame counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_r      <= 1'b0;
      beat_r      <= {BEAT_W{1'b0}};
      frame_cnt_r <= {FCNT_W{1'b0}};
    end else begin
      pend_r <= fifo_rd_en;
      if (pop_s) begin
        if (out_last) begin
          beat_r      <= {BEAT_W{1'b0}};
          frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
        end else begin
          beat_r <= beat_r + BEAT_W'(1);
        end
      end
    end
  end

  stream_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (pend_r),
    .wdata (fifo_data),
    .rd    (pop_s),
    .rdata (out_data),
    .occ   (occ_s)
  );

endmodule
